// File: rtl/mindfocus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// Package : mindfocus_pkg
// Purpose : Shared state codes and timing defaults for the MindFocus judge.
// Revision: 1.0
// ----------------------------------------------------------------------
package mindfocus_pkg;

  localparam int ESPERA_MS_PADRAO = 5000;
  localparam int JANELA_MS_PADRAO = 10000;
  localparam int RODADAS_PADRAO   = 3;
  localparam int N_BOTOES_PADRAO  = 4;

  // Enum values double as the db_estado display codes.
  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ESPERA   = 4'd2,
    JANELA   = 4'd3,
    REGISTRA = 4'd4,
    COMPARA  = 4'd5,
    SOLTA    = 4'd6,
    PROXIMA  = 4'd7,
    FIM      = 4'd15
  } estado_t;

  function automatic int largura_timer(input int a, input int b);
    int maior;
    maior = (a > b) ? a : b;
    return $clog2(maior + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// ----------------------------------------------------------------------
// Module  : contador_m
// Purpose : Modulo-M up counter that parks at M-1 instead of wrapping.
// Revision: 1.0
// ----------------------------------------------------------------------
module contador_m #(
  parameter int M = 10,
  parameter int W = $clog2(M + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] Q,
  output logic         fim
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      Q <= '0;
    end else if (conta && (Q != ULTIMO)) begin
      Q <= Q + W'(1);
    end
  end

  assign fim = (Q == ULTIMO);

endmodule
`default_nettype wire

// File: rtl/mindfocus_juiz_jogada.sv
`default_nettype none
// ----------------------------------------------------------------------
// Module  : mindfocus_juiz_jogada
// Purpose : Paces MindFocus rounds and judges the player's button plays.
// Revision: 1.0
// ----------------------------------------------------------------------
module mindfocus_juiz_jogada
  import mindfocus_pkg::*;
#(
  parameter int ESPERA_MS = ESPERA_MS_PADRAO,
  parameter int JANELA_MS = JANELA_MS_PADRAO,
  parameter int RODADAS   = RODADAS_PADRAO,
  parameter int N_BOTOES  = N_BOTOES_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                voltar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] esperado,
  output logic [3:0]          indice,
  output logic                janela,
  output logic                tem_jogada,
  output logic                igual_jogada,
  output logic                timeout,
  output logic [3:0]          acertos,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  localparam int         TW          = largura_timer(ESPERA_MS, JANELA_MS);
  localparam logic [3:0] ULTIMA      = 4'(RODADAS - 1);
  localparam logic [3:0] MAX_ACERTOS = 4'(RODADAS);

  estado_t             estado;
  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] jogada;
  logic [TW-1:0]       q_espera;
  logic [TW-1:0]       q_janela;
  logic                fim_espera;
  logic                fim_janela;
  logic                borda;
  logic                um_quente;
  logic                unused_q;

  // The hold-off counter is one longer than ESPERA_MS so the window opens
  // ESPERA_MS+1 cycles after ESPERA is entered.
  contador_m #(.M(ESPERA_MS + 1), .W(TW)) u_espera (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ESPERA),
    .conta (estado == ESPERA),
    .Q     (q_espera),
    .fim   (fim_espera)
  );

  contador_m #(.M(JANELA_MS), .W(TW)) u_janela (
    .clock (clock),
    .reset (reset),
    .zera  (estado != JANELA),
    .conta (estado == JANELA),
    .Q     (q_janela),
    .fim   (fim_janela)
  );

  assign unused_q = ^{q_espera, q_janela};

  // ESPERA only exits with buttons released, so botoes_ant is zero on the
  // first window cycle and a button held over from earlier never counts.
  assign borda     = (botoes_ant == '0) && (botoes != '0);
  assign um_quente = (jogada != '0) && ((jogada & (jogada - N_BOTOES'(1))) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_ant <= '0;
    end else begin
      botoes_ant <= botoes;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || voltar) begin
      estado       <= INICIAL;
      indice       <= 4'd0;
      acertos      <= 4'd0;
      jogada       <= '0;
      tem_jogada   <= 1'b0;
      igual_jogada <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tem_jogada   <= 1'b0;
      igual_jogada <= 1'b0;
      timeout      <= 1'b0;
      case (estado)
        INICIAL: if (iniciar) estado <= PREPARA;
        PREPARA: begin
          acertos <= 4'd0;
          indice  <= 4'd0;
          estado  <= ESPERA;
        end
        ESPERA: if (fim_espera && (botoes == '0)) estado <= JANELA;
        JANELA: begin
          // A play on the terminal cycle takes precedence over the timeout.
          if (borda) begin
            jogada <= botoes;
            estado <= REGISTRA;
          end else if (fim_janela) begin
            timeout <= 1'b1;
            estado  <= PROXIMA;
          end
        end
        REGISTRA: begin
          tem_jogada   <= 1'b1;
          igual_jogada <= um_quente && (jogada == esperado);
          estado       <= COMPARA;
        end
        COMPARA: begin
          if (igual_jogada && (acertos != MAX_ACERTOS)) acertos <= acertos + 4'd1;
          estado <= SOLTA;
        end
        SOLTA: if (botoes == '0) estado <= PROXIMA;
        PROXIMA: begin
          if (indice == ULTIMA) begin
            estado <= FIM;
          end else begin
            indice <= indice + 4'd1;
            estado <= ESPERA;
          end
        end
        FIM: if (iniciar) estado <= PREPARA;
        default: estado <= INICIAL;
      endcase
    end
  end

  assign janela    = (estado == JANELA);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule
`default_nettype wire

// File: doc/mindfocus_juiz_jogada.md
Name: mindfocus_juiz_jogada

Overview:
- Response-side judge of the MindFocus game. After `iniciar` it paces each round: a fixed hold-off, then a timed response window.
- During the window it captures one button play, compares it with the expected one-hot value from the game datapath, and counts hits.
- It is the game-side counterpart of the player stimulus: it consumes `botoes` and produces `tem_jogada`, `igual_jogada`, `acertos` and `pronto` for the top level and the debug displays.

Parameters:
- ESPERA_MS, 5000, hold-off cycles before each window opens (1 cycle = 1 ms at the 1 kHz game clock).
- JANELA_MS, 10000, response-window length in cycles.
- RODADAS, 3, rounds per game (1..15).
- N_BOTOES, 4, button count.

Ports:
- clock  in  1  game clock, rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start a game (level sampled; one cycle sufficient).
- voltar  in  1  abort to idle, synchronous, priority below reset.
- botoes  in  N_BOTOES  raw button levels, already synchronised.
- esperado  in  N_BOTOES  expected one-hot play for the current round.
- indice  out  4  current round number, 0..RODADAS-1.
- janela  out  1  high while the response window is open.
- tem_jogada  out  1  one-cycle pulse when a play is captured.
- igual_jogada  out  1  one-cycle pulse, coincident with tem_jogada, when the play equals esperado.
- timeout  out  1  one-cycle pulse when a window expires without a play.
- acertos  out  4  hit count for the current game.
- pronto  out  1  high while in FIM.
- db_estado  out  4  state code.

Behaviour:
- Reset (synchronous, active-high) forces INICIAL. All outputs are 0 in INICIAL; acertos and indice hold 0.
- States and codes: INICIAL=0, PREPARA=1, ESPERA=2, JANELA=3, REGISTRA=4, COMPARA=5, SOLTA=6, PROXIMA=7, FIM=15.
- INICIAL: iniciar=1 -> PREPARA.
- PREPARA, 1 cycle: clear acertos, indice and timers -> ESPERA.
- ESPERA:
  - Count ESPERA_MS cycles. At terminal count, go to JANELA only if botoes==0; otherwise stay until release.
  - A button held from the previous round is never a play.
- JANELA:
  - janela=1; count JANELA_MS cycles.
  - A play is the first cycle in which the registered previous botoes==0 and the current botoes!=0. Capture botoes into the jogada register -> REGISTRA.
  - Terminal count with no play: pulse timeout -> PROXIMA. No hit.
  - Play and terminal count in the same cycle: the play wins.
- REGISTRA, 1 cycle: pulse tem_jogada. igual_jogada = (jogada==esperado), and only when jogada is one-hot. Multi-bit plays are misses. -> COMPARA.
- COMPARA, 1 cycle: if it was a hit, acertos <= acertos+1, saturating at RODADAS -> SOLTA.
- SOLTA: wait for botoes==0 -> PROXIMA. No timer runs.
- PROXIMA, 1 cycle:
  - indice==RODADAS-1 -> FIM.
  - Otherwise indice+1, restart the ESPERA timer -> ESPERA.
- FIM:
  - pronto=1; acertos and indice hold.
  - iniciar -> PREPARA (new game).
- voltar=1 in any state -> INICIAL next cycle; acertos and indice cleared.
- reset and voltar together: reset wins (same result).
- Latency:
  - Button edge in JANELA to tem_jogada: 2 cycles.
  - tem_jogada to acertos update: 1 cycle.
  - Window opens exactly ESPERA_MS+1 cycles after entering ESPERA with buttons released.
- Timer widths: ceil(log2(max(ESPERA_MS, JANELA_MS)+1)), unsigned, no wrap past terminal.

Decomposition:
- Package mindfocus_pkg:
  - State encoding constants.
  - db_estado codes.
  - Default ESPERA_MS / JANELA_MS.
- One sub-module, contador_m: parameter M; inputs clock, reset, zera, conta; outputs Q and fim (Q==M-1). Two instances: espera and janela.
- Edge detector and jogada register stay in this block.

Test Plan:
1. Reset then iniciar pulse, botoes=0 throughout -> janela rises 5001 cycles after ESPERA entry; 3 timeout pulses 10000 cycles apart (plus hold-off); FIM with acertos=0, pronto=1.
2. Each round: esperado=4'b1000, press botoes=4'b1000 7 cycles after janela rises, hold 10000 cycles -> tem_jogada+igual_jogada 2 cycles after the press; next ESPERA starts only after release. After 3 rounds: acertos=3, pronto=1.
3. esperado=4'b0100, press 4'b1000 -> tem_jogada=1, igual_jogada=0, acertos unchanged. Press 4'b1100 with esperado=4'b1000 -> miss.
4. Hold 4'b1000 from inside ESPERA through the window start -> window does not open until release; a press after the opening counts. A press arriving on the window's last cycle counts as a play, not a timeout.
5. voltar asserted mid-JANELA in round 1 with acertos=1 -> INICIAL next cycle, acertos=0, indice=0, janela=0. Then iniciar starts a fresh game.
6. In FIM, pulse iniciar -> PREPARA; acertos clears to 0 and the full 3-round sequence repeats.
